// File: rtl/imem_loader.sv
// Byte-stream IMEM loader: parses a framed, XOR-checksummed image into IMEM word writes.
// The core is held in reset until the frame checksum is verified.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [15:0]       words_loaded
);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {HDR0, HDR1, PAYLOAD, CHK, DONE, ERROR} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  bsel;
  logic [23:0] wbuf;
  logic [7:0]  xsum;
  logic [16:0] hdr_cnt;
  logic        accept;

  assign s_ready = reset && (state != DONE) && (state != ERROR);
  assign accept  = s_valid && s_ready;
  assign hdr_cnt = {1'b0, s_data, cnt[7:0]};

  // words_loaded doubles as the running word index into IMEM
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= HDR0;
      cnt          <= '0;
      bsel         <= '0;
      wbuf         <= '0;
      xsum         <= '0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      core_hold    <= 1'b1;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        if (state != CHK) xsum <= xsum ^ s_data;
        case (state)
          HDR0: begin
            cnt[7:0] <= s_data;
            state    <= HDR1;
          end
          HDR1: begin
            cnt[15:8] <= s_data;
            if (hdr_cnt > MAX_WORDS) begin
              state      <= ERROR;
              load_error <= 1'b1;
            end else if (hdr_cnt == 17'd0) begin
              state <= CHK;
            end else begin
              state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            bsel <= bsel + 2'd1;
            case (bsel)
              2'd0: wbuf[7:0]   <= s_data;
              2'd1: wbuf[15:8]  <= s_data;
              2'd2: wbuf[23:16] <= s_data;
              default: begin
                imem_we      <= 1'b1;
                imem_waddr   <= words_loaded[ADDR_W-1:0];
                imem_wdata   <= {s_data, wbuf};
                words_loaded <= words_loaded + 16'd1;
                if (words_loaded + 16'd1 == cnt) state <= CHK;
              end
            endcase
          end
          CHK: begin
            if (s_data == xsum) begin
              state     <= DONE;
              load_done <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame-level reference model checked every cycle, plus literal
// expectations for the directed scenarios.
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int MAXW   = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'h00;
  logic              s_ready, imem_we, core_hold, load_done, load_error;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic [15:0]       words_loaded;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .load_done(load_done), .load_error(load_error),
    .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  int nvec = 0, nfail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: the frame is the list of accepted bytes; outputs follow from its length.
  logic [7:0]  fb[$];
  logic        m_we, m_done, m_err, started;
  logic [31:0] m_addr, m_data;
  int          m_wl;
  logic [39:0] wlog[$];

  initial begin
    m_we = 0; m_done = 0; m_err = 0; started = 0;
    m_addr = 0; m_data = 0; m_wl = 0;
  end

  always @(posedge clock) begin
    int n, cnt, p;
    logic [7:0] x;
    logic acc;
    acc = reset && s_valid && !m_done && !m_err;
    m_we = 0;
    if (!reset) begin
      started = 1;
      fb.delete();
      m_addr = 0; m_data = 0; m_wl = 0; m_done = 0; m_err = 0;
    end else if (acc) begin
      fb.push_back(s_data);
      n = fb.size();
      if (n >= 2) begin
        cnt = int'(fb[0]) + 256 * int'(fb[1]);
        if (cnt > MAXW) m_err = 1;
        else if (n > 2 && n <= 2 + 4 * cnt) begin
          p = n - 3;
          if (p % 4 == 3) begin
            m_we = 1;
            m_addr = p / 4;
            m_data = {fb[n-1], fb[n-2], fb[n-3], fb[n-4]};
            m_wl++;
          end
        end else if (n == 3 + 4 * cnt) begin
          x = 0;
          for (int i = 0; i < n - 1; i++) x ^= fb[i];
          if (x == fb[n-1]) m_done = 1; else m_err = 1;
        end
      end
    end
    #1;
    if (started) begin
      check("imem_we", 32'(imem_we), 32'(m_we));
      check("imem_waddr", 32'(imem_waddr), m_addr);
      check("imem_wdata", imem_wdata, m_data);
      check("words_loaded", 32'(words_loaded), 32'(m_wl));
      check("load_done", 32'(load_done), 32'(m_done));
      check("load_error", 32'(load_error), 32'(m_err));
      check("core_hold", 32'(core_hold), 32'(!m_done));
      check("s_ready", 32'(s_ready), 32'(reset && !m_done && !m_err));
      if (imem_we === 1'b1) wlog.push_back({imem_waddr, imem_wdata});
    end
  end

  logic [7:0] stim[$];

  task automatic do_reset();
    @(negedge clock);
    reset = 0; s_valid = 0;
    repeat (2) @(negedge clock);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_hold", 32'(core_hold), 32'd1);
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    reset = 1;
    wlog.delete();
  endtask

  // Present bytes with optional random valid gaps; bytes refused by a closed loader are dropped.
  task automatic send(input int nbytes, input int gapmax);
    for (int i = 0; i < nbytes && i < stim.size(); i++) begin
      int g;
      g = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
      repeat (g) begin
        @(negedge clock);
        s_valid = 0; s_data = 8'($urandom);
      end
      @(negedge clock);
      s_valid = 1; s_data = stim[i];
    end
    @(negedge clock);
    s_valid = 0;
    repeat (3) @(negedge clock);
  endtask

  task automatic build(input int cnt, input bit corrupt);
    logic [7:0] x;
    logic [31:0] w;
    stim.delete();
    stim.push_back(8'(cnt));
    stim.push_back(8'(cnt >> 8));
    for (int i = 0; i < cnt; i++) begin
      w = $urandom;
      for (int k = 0; k < 4; k++) stim.push_back(w[8*k +: 8]);
    end
    x = 0;
    foreach (stim[i]) x ^= stim[i];
    stim.push_back(corrupt ? x ^ 8'(1 << $urandom_range(0, 7)) : x);
  endtask

  task automatic load_sc1(input logic [7:0] chk);
    stim = '{8'h02, 8'h00, 8'h93, 8'h01, 8'h10, 8'h01, 8'h13, 8'h82, 8'h31, 8'h00};
    stim.push_back(chk);
  endtask

  task automatic check_sc1_writes(input string tag);
    check({tag, "_nwr"}, 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      check({tag, "_w0"}, wlog[0][31:0], 32'h01100193);
      check({tag, "_a0"}, 32'(wlog[0][39:32]), 32'd0);
      check({tag, "_w1"}, wlog[1][31:0], 32'h00318213);
      check({tag, "_a1"}, 32'(wlog[1][39:32]), 32'd1);
    end
  endtask

  initial begin
    // Scenario 1: two-word image, good checksum
    do_reset();
    load_sc1(8'h21);
    send(stim.size(), 0);
    check_sc1_writes("sc1");
    check("sc1_words", 32'(words_loaded), 32'd2);
    check("sc1_done", 32'(load_done), 32'd1);
    check("sc1_hold", 32'(core_hold), 32'd0);
    check("sc1_ready", 32'(s_ready), 32'd0);

    // Scenario 2: bad checksum keeps the written words
    do_reset();
    load_sc1(8'h22);
    send(stim.size(), 0);
    check_sc1_writes("sc2");
    check("sc2_err", 32'(load_error), 32'd1);
    check("sc2_done", 32'(load_done), 32'd0);
    check("sc2_hold", 32'(core_hold), 32'd1);

    // Scenario 3: empty image
    do_reset();
    stim = '{8'h00, 8'h00, 8'h00};
    send(stim.size(), 0);
    check("sc3_nwr", 32'(wlog.size()), 32'd0);
    check("sc3_done", 32'(load_done), 32'd1);
    check("sc3_hold", 32'(core_hold), 32'd0);
    check("sc3_words", 32'(words_loaded), 32'd0);

    // Scenario 4: length 257 is too large; trailing bytes must be refused
    do_reset();
    stim = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
    send(stim.size(), 0);
    check("sc4_nwr", 32'(wlog.size()), 32'd0);
    check("sc4_err", 32'(load_error), 32'd1);
    check("sc4_ready", 32'(s_ready), 32'd0);

    // Scenario 5: scenario 1 with valid gaps
    do_reset();
    load_sc1(8'h21);
    send(stim.size(), 3);
    check_sc1_writes("sc5");
    check("sc5_done", 32'(load_done), 32'd1);

    // Scenario 6: reset mid-frame, then replay
    do_reset();
    load_sc1(8'h21);
    send(5, 0);
    do_reset();
    send(stim.size(), 0);
    check_sc1_writes("sc6");
    check("sc6_done", 32'(load_done), 32'd1);

    // Largest legal image: last address is MAX_WORDS-1
    do_reset();
    build(MAXW, 0);
    send(stim.size(), 0);
    check("max_nwr", 32'(wlog.size()), 32'(MAXW));
    if (wlog.size() == MAXW) check("max_last_addr", 32'(wlog[MAXW-1][39:32]), 32'(MAXW - 1));
    check("max_done", 32'(load_done), 32'd1);

    // Randomized frames, some corrupted, some cut by reset
    for (int t = 0; t < 40; t++) begin
      int cnt;
      do_reset();
      cnt = $urandom_range(0, 8);
      build(cnt, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) begin
        send($urandom_range(1, stim.size()), 2);
        do_reset();
        build(cnt, 0);
      end
      send(stim.size(), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
